// File: rtl/dma_uart_mem_system.sv
// ---------------------------------------------------------------------------
// dma_uart_mem_system
//
// CPU-controlled DMA subsystem. A start pulse copies transfer_size bytes from
// a 16-byte UART receive buffer (preloaded with "Advanced Digital") into a
// 256x8 data memory, beginning at start_address, and then raises done.
// Each byte takes three cycles: UART read, wait for data valid, memory write.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous, active-high reset
//   start             one-cycle transfer request (ignored while busy)
//   start_address     destination base address, sampled with start
//   transfer_size     byte count, sampled with start (0 = no transfer)
//   done              registered, high while the DMA FSM is in DONE
//   mem_read_address  CPU side-port read address
//   mem_read_enable   CPU side-port read strobe
//   mem_read_data     registered CPU read data, 1-cycle latency
//   uart_reset_ptr    returns the UART read pointer to 0
// ---------------------------------------------------------------------------

// UART receive buffer: constant ROM with an auto-incrementing read pointer.
module uart_rx_buffer #(
    parameter int DATA_WIDTH       = 8,
    parameter int UART_BUFFER_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_enable,
    input  logic                  reset_ptr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  data_valid
);
    localparam int PTR_W = $clog2(UART_BUFFER_SIZE);

    logic [PTR_W-1:0] ptr;

    function automatic logic [DATA_WIDTH-1:0] rom_byte(input logic [PTR_W-1:0] idx);
        logic [DATA_WIDTH-1:0] b;
        case (int'(idx))
            0:       b = DATA_WIDTH'(8'h41);
            1:       b = DATA_WIDTH'(8'h64);
            2:       b = DATA_WIDTH'(8'h76);
            3:       b = DATA_WIDTH'(8'h61);
            4:       b = DATA_WIDTH'(8'h6E);
            5:       b = DATA_WIDTH'(8'h63);
            6:       b = DATA_WIDTH'(8'h65);
            7:       b = DATA_WIDTH'(8'h64);
            8:       b = DATA_WIDTH'(8'h20);
            9:       b = DATA_WIDTH'(8'h44);
            10:      b = DATA_WIDTH'(8'h69);
            11:      b = DATA_WIDTH'(8'h67);
            12:      b = DATA_WIDTH'(8'h69);
            13:      b = DATA_WIDTH'(8'h74);
            14:      b = DATA_WIDTH'(8'h61);
            15:      b = DATA_WIDTH'(8'h6C);
            default: b = '0;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= read_enable;
            if (read_enable)
                rx_data <= rom_byte(ptr);
            // Pointer reset wins over a simultaneous read increment; the
            // read itself still returns data.
            if (reset_ptr)
                ptr <= '0;
            else if (read_enable)
                ptr <= ptr + PTR_W'(1);
        end
    end
endmodule

// DMA controller FSM: one byte per READ_UART -> WAIT_DATA -> WRITE_MEM round.
module dma_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int SIZE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [SIZE_WIDTH-1:0] transfer_size,
    input  logic                  uart_data_valid,
    input  logic [DATA_WIDTH-1:0] uart_rx_data,
    output logic                  done,
    output logic                  uart_read_enable,
    output logic                  memory_write_enable,
    output logic [ADDR_WIDTH-1:0] memory_write_address,
    output logic [DATA_WIDTH-1:0] memory_write_data
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_UART = 3'd1,
        WAIT_DATA = 3'd2,
        WRITE_MEM = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                current_state;
    state_t                next_state;
    logic                  latch_params;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [SIZE_WIDTH-1:0] xfer_size;
    logic [SIZE_WIDTH-1:0] byte_count;
    logic [DATA_WIDTH-1:0] data_byte;

    always_comb begin
        next_state          = current_state;
        uart_read_enable    = 1'b0;
        memory_write_enable = 1'b0;
        latch_params        = 1'b0;
        case (current_state)
            // DONE behaves like IDLE for a new start, so back-to-back
            // transfers need no extra return-to-idle cycle.
            IDLE, DONE: begin
                if (start) begin
                    latch_params = 1'b1;
                    next_state   = (transfer_size == '0) ? DONE : READ_UART;
                end
            end
            READ_UART: begin
                uart_read_enable = 1'b1;
                next_state       = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (uart_data_valid)
                    next_state = WRITE_MEM;
            end
            WRITE_MEM: begin
                memory_write_enable = 1'b1;
                next_state = (byte_count + SIZE_WIDTH'(1) == xfer_size) ? DONE : READ_UART;
            end
            default: next_state = IDLE;
        endcase
    end

    // Destination address wraps modulo the memory size.
    assign memory_write_address = base_addr + ADDR_WIDTH'(byte_count);
    assign memory_write_data    = data_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            current_state <= IDLE;
            done          <= 1'b0;
            base_addr     <= '0;
            xfer_size     <= '0;
            byte_count    <= '0;
        end else begin
            current_state <= next_state;
            done          <= (next_state == DONE);
            if (latch_params) begin
                base_addr  <= start_address;
                xfer_size  <= transfer_size;
                byte_count <= '0;
            end else if (current_state == WRITE_MEM) begin
                byte_count <= byte_count + SIZE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (current_state == WAIT_DATA && uart_data_valid)
            data_byte <= uart_rx_data;
    end
endmodule

// Data memory: one write port (DMA) and one registered read port (CPU).
module data_memory #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int MEMORY_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] read_data
);
    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    // Contents survive reset; a write coinciding with reset is dropped so an
    // aborted transfer leaves no further bytes behind.
    always_ff @(posedge clk) begin
        if (write_enable && !rst)
            mem[write_address] <= write_data;
    end

    // Read-before-write: a same-cycle read of the written address sees old data.
    always_ff @(posedge clk) begin
        if (rst)
            read_data <= '0;
        else if (read_enable)
            read_data <= mem[read_address];
    end
endmodule

module dma_uart_mem_system #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 8,
    parameter int SIZE_WIDTH       = 8,
    parameter int MEMORY_DEPTH     = 256,
    parameter int UART_BUFFER_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [SIZE_WIDTH-1:0] transfer_size,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic                  mem_read_enable,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  uart_reset_ptr
);
    logic                  uart_read_enable;
    logic                  uart_data_valid;
    logic [DATA_WIDTH-1:0] uart_rx_data;
    logic                  memory_write_enable;
    logic [ADDR_WIDTH-1:0] memory_write_address;
    logic [DATA_WIDTH-1:0] memory_write_data;

    uart_rx_buffer #(
        .DATA_WIDTH       (DATA_WIDTH),
        .UART_BUFFER_SIZE (UART_BUFFER_SIZE)
    ) uart_inst (
        .clk         (clk),
        .rst         (rst),
        .read_enable (uart_read_enable),
        .reset_ptr   (uart_reset_ptr),
        .rx_data     (uart_rx_data),
        .data_valid  (uart_data_valid)
    );

    dma_controller #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SIZE_WIDTH (SIZE_WIDTH)
    ) dma_inst (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .start_address        (start_address),
        .transfer_size        (transfer_size),
        .uart_data_valid      (uart_data_valid),
        .uart_rx_data         (uart_rx_data),
        .done                 (done),
        .uart_read_enable     (uart_read_enable),
        .memory_write_enable  (memory_write_enable),
        .memory_write_address (memory_write_address),
        .memory_write_data    (memory_write_data)
    );

    data_memory #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH)
    ) mem_inst (
        .clk           (clk),
        .rst           (rst),
        .write_enable  (memory_write_enable),
        .write_address (memory_write_address),
        .write_data    (memory_write_data),
        .read_enable   (mem_read_enable),
        .read_address  (mem_read_address),
        .read_data     (mem_read_data)
    );
endmodule

// File: tb/tb_dma_uart_mem_system.sv
module tb_dma_uart_mem_system;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] start_address;
    logic [7:0] transfer_size;
    logic       done;
    logic [7:0] mem_read_address;
    logic       mem_read_enable;
    logic [7:0] mem_read_data;
    logic       uart_reset_ptr;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;

    logic [7:0] str_tbl [16] = '{8'h41, 8'h64, 8'h76, 8'h61, 8'h6E, 8'h63, 8'h65, 8'h64,
                                 8'h20, 8'h44, 8'h69, 8'h67, 8'h69, 8'h74, 8'h61, 8'h6C};

    always #5 clk = ~clk;

    dma_uart_mem_system dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .start_address    (start_address),
        .transfer_size    (transfer_size),
        .done             (done),
        .mem_read_address (mem_read_address),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data),
        .uart_reset_ptr   (uart_reset_ptr)
    );

    // Count memory write strobes seen at each rising edge.
    always @(posedge clk) begin
        if (dut.memory_write_enable === 1'b1)
            wr_count <= wr_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] s);
        start         = 1'b1;
        start_address = a;
        transfer_size = s;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_ptr_reset();
        uart_reset_ptr = 1'b1;
        tick();
        uart_reset_ptr = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic read_mem(input logic [7:0] a, output logic [7:0] d);
        mem_read_address = a;
        mem_read_enable  = 1'b1;
        tick();
        mem_read_enable = 1'b0;
        d = mem_read_data;
    endtask

    initial begin
        logic [7:0] d;
        int         snap;
        int         n;

        rst              = 1'b1;
        start            = 1'b0;
        start_address    = '0;
        transfer_size    = '0;
        mem_read_address = '0;
        mem_read_enable  = 1'b0;
        uart_reset_ptr   = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", {24'd0, mem_read_data}, 32'h0);
        check("rst_state", {29'd0, dut.dma_inst.current_state}, 32'd0);
        check("rst_ure", {31'd0, dut.uart_read_enable}, 32'd0);
        check("rst_valid", {31'd0, dut.uart_data_valid}, 32'd0);
        check("rst_mwe", {31'd0, dut.memory_write_enable}, 32'd0);
        rst = 1'b0;
        tick();

        // 4 bytes to 0x10, with a start pulse while busy that must be ignored
        pulse_ptr_reset();
        do_start(8'h10, 8'd4);
        repeat (3) tick();
        do_start(8'h90, 8'd1);
        wait_done("t1_done", 200);
        for (int i = 0; i < 4; i++) begin
            read_mem(8'h10 + 8'(i), d);
            check($sformatf("t1_mem%0d", i), {24'd0, d}, {24'd0, str_tbl[i]});
        end

        // Single byte to 0x20, exactly one write strobe
        pulse_ptr_reset();
        snap = wr_count;
        do_start(8'h20, 8'd1);
        wait_done("t2_done", 20);
        check("t2_writes", wr_count - snap, 32'd1);
        read_mem(8'h20, d);
        check("t2_mem", {24'd0, d}, 32'h41);

        // Full 16-byte string to 0x40, starting from DONE
        pulse_ptr_reset();
        check("t3_done_before", {31'd0, done}, 32'd1);
        snap = wr_count;
        do_start(8'h40, 8'd16);
        check("t3_done_fall", {31'd0, done}, 32'd0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("t3_latency", n, 32'd48);
        check("t3_writes_at_done", wr_count - snap, 32'd16);
        for (int i = 0; i < 16; i++) begin
            read_mem(8'h40 + 8'(i), d);
            check($sformatf("t3_mem%0d", i), {24'd0, d}, {24'd0, str_tbl[i]});
        end

        // Reset mid-transfer aborts
        pulse_ptr_reset();
        do_start(8'h60, 8'd8);
        repeat (5) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        snap = wr_count;
        repeat (3) tick();
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_ure", {31'd0, dut.uart_read_enable}, 32'd0);
        check("t4_mwe", {31'd0, dut.memory_write_enable}, 32'd0);
        check("t4_state", {29'd0, dut.dma_inst.current_state}, 32'd0);
        check("t4_no_writes", wr_count - snap, 32'd0);
        read_mem(8'h60, d);
        check("t4_partial", {24'd0, d}, 32'h41);

        // Two bytes to 0x70 (pointer left at 2), zero-size start, then wrap
        do_start(8'h70, 8'd2);
        wait_done("t5_done_a", 20);
        read_mem(8'h70, d);
        check("t5_mem70", {24'd0, d}, 32'h41);
        read_mem(8'h71, d);
        check("t5_mem71", {24'd0, d}, 32'h64);

        snap = wr_count;
        do_start(8'h80, 8'd0);
        n = 0;
        while (done !== 1'b1 && n < 2) begin
            tick();
            n++;
        end
        check("t5_zero_done", {31'd0, done}, 32'd1);
        check("t5_zero_writes", wr_count - snap, 32'd0);

        do_start(8'hFE, 8'd3);
        wait_done("t5_done_b", 20);
        read_mem(8'hFE, d);
        check("t5_memFE", {24'd0, d}, 32'h76);
        read_mem(8'hFF, d);
        check("t5_memFF", {24'd0, d}, 32'h61);
        read_mem(8'h00, d);
        check("t5_mem00", {24'd0, d}, 32'h6E);

        // Read data holds while the enable is low
        mem_read_address = 8'hFE;
        tick();
        check("rdata_hold", {24'd0, mem_read_data}, 32'h6E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dma_uart_mem_system.md
Name: dma_uart_mem_system

Overview:
- Self-contained CPU-controlled DMA subsystem with three parts: a 16-byte UART receive buffer, a DMA controller FSM, and a 256x8 data memory.
- On a CPU start pulse, the DMA copies transfer_size bytes from the UART buffer into memory beginning at start_address, then raises done.
- A side read port lets the CPU or bench inspect memory.
- The UART buffer is preloaded with the ASCII string "Advanced Digital".

Parameters:
- DATA_WIDTH, 8, byte width of UART and memory data
- ADDR_WIDTH, 8, memory address width
- SIZE_WIDTH, 8, transfer-size / byte-counter width
- MEMORY_DEPTH, 256, number of memory words
- UART_BUFFER_SIZE, 16, UART buffer depth (pointer width = log2)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle CPU request to begin a transfer
- start_address  in  ADDR_WIDTH  destination base address, sampled with start
- transfer_size  in  SIZE_WIDTH  byte count, sampled with start
- done  out  1  registered; high while the FSM is in DONE
- mem_read_address  in  ADDR_WIDTH  CPU read address
- mem_read_enable  in  1  CPU read strobe
- mem_read_data  out  DATA_WIDTH  registered CPU read data
- uart_reset_ptr  in  1  synchronously returns the UART read pointer to 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (rst).
- Bench-visible internal nets: uart_read_enable, uart_data_valid, memory_write_enable, memory_write_address, memory_write_data, dma_inst.current_state.
- Reset forces:
  - FSM to IDLE
  - done, uart_read_enable, uart_data_valid, memory_write_enable to 0
  - UART pointer to 0; byte counter, latched address and latched size to 0
  - mem_read_data to 0
  - Memory contents are not cleared. UART buffer contents are constant ROM.
- UART buffer contents, index 0..15: 41 64 76 61 6E 63 65 64 20 44 69 67 69 74 61 6C (hex).
- UART buffer read:
  - When uart_read_enable=1 on an edge, uart_rx_data <= buf[ptr], uart_data_valid <= 1 for one cycle, ptr <= ptr+1 mod 16 (wraps 15->0).
  - uart_reset_ptr=1 sets ptr <= 0 and overrides a simultaneous read increment; the read data is still returned.
- Memory write: when memory_write_enable=1 on an edge, mem[memory_write_address] <= memory_write_data.
- Memory read:
  - When mem_read_enable=1, mem_read_data <= mem[mem_read_address] at the next edge. Latency is 1 cycle.
  - mem_read_data holds its value when enable is 0.
  - A read and a write to the same address in the same cycle returns the old data.
- DMA FSM states: IDLE, READ_UART, WAIT_DATA, WRITE_MEM, DONE.
  - IDLE: on start, latch base=start_address, size=transfer_size, count=0. Go to DONE if size==0, else READ_UART.
  - READ_UART: assert uart_read_enable for exactly this cycle, then go to WAIT_DATA.
  - WAIT_DATA: when uart_data_valid=1, capture the data and go to WRITE_MEM.
  - WRITE_MEM:
    - memory_write_enable=1, memory_write_address = base+count (mod 256), memory_write_data = captured byte; count++.
    - If count+1==size go to DONE, else READ_UART.
  - DONE: done=1. Stay until start. On start, latch new parameters, clear done in the same edge, and proceed as from IDLE.
- Enables are asserted only in their named states and are 0 everywhere else.
- Throughput: 3 cycles per byte. A 16-byte transfer finishes in ≤52 cycles after start.
- start while busy (not IDLE/DONE) is ignored.
- Sizes above 16 keep wrapping the UART pointer, so the string repeats.
- rst mid-transfer aborts immediately. Partial writes already done remain; there are no further writes.

Test Plan:
- Reset, pulse uart_reset_ptr, start addr 0x10 size 4 -> done within 200 cycles; mem[0x10..0x13] = 41 64 76 61.
- uart_reset_ptr, start addr 0x20 size 1 -> done; mem[0x20] = 41; exactly one memory_write_enable pulse.
- uart_reset_ptr, start addr 0x40 size 16 -> mem[0x40..0x4F] = full string 41..6C; done falls on the edge sampling start, rises after the last write.
- uart_reset_ptr, start addr 0x60 size 8, 5 cycles later rst for 2 cycles -> 3 cycles after release: done=0, uart_read_enable=0, memory_write_enable=0, state IDLE.
- Start size 0 -> done within 2 cycles, no memory writes; a second start without uart_reset_ptr at addr 0xFE size 3 -> continues from the current pointer, addresses wrap to 0xFE, 0xFF, 0x00.
